// File: rtl/amp_preprocessor_seq_if.sv
// -----------------------------------------------------------------------------
// amp_preprocessor_seq_if
//   Bus bundle for the time-multiplexed note-amplitude preprocessor.
//   Amplitudes are unsigned W.D fixed point, one W+D-bit word per bin.
//
//   Signals
//     start                 frame request (level, sampled while the block is idle)
//     noteAmplitudes_i      [BIN_QTY][W+D] frame input
//     noteAmplitudes_o      [BIN_QTY][W+D] slow-filtered amplitudes
//     noteAmplitudesFast_o  [BIN_QTY][W+D] fast-filtered amplitudes
//     amplitudeSumNew_o     [W+D+clog2(BIN_QTY)] sum of floored amplitudes
//     data_v                one-cycle frame-done pulse
//     busy                  high while a frame is being processed
//     peakIdx_o / peakAmp_o only when AMPPRE_PEAK_EN is defined
//
//   Modports: master = frame producer/consumer, slave = preprocessor.
//   Optional feature macro: AMPPRE_PEAK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface amp_preprocessor_seq_if #(
   parameter int W       = 6,
   parameter int D       = 10,
   parameter int BIN_QTY = 12
);
   localparam int AW = W + D;
   localparam int IW = $clog2(BIN_QTY);
   localparam int SW = AW + IW;

   logic                        start;
   logic [BIN_QTY-1:0][AW-1:0]  noteAmplitudes_i;
   logic [BIN_QTY-1:0][AW-1:0]  noteAmplitudes_o;
   logic [BIN_QTY-1:0][AW-1:0]  noteAmplitudesFast_o;
   logic [SW-1:0]               amplitudeSumNew_o;
   logic                        data_v;
   logic                        busy;
`ifdef AMPPRE_PEAK_EN
   logic [IW-1:0]               peakIdx_o;
   logic [AW-1:0]               peakAmp_o;

   modport master (
      output start, noteAmplitudes_i,
      input  noteAmplitudes_o, noteAmplitudesFast_o, amplitudeSumNew_o,
             data_v, busy, peakIdx_o, peakAmp_o
   );
   modport slave (
      input  start, noteAmplitudes_i,
      output noteAmplitudes_o, noteAmplitudesFast_o, amplitudeSumNew_o,
             data_v, busy, peakIdx_o, peakAmp_o
   );
`else
   modport master (
      output start, noteAmplitudes_i,
      input  noteAmplitudes_o, noteAmplitudesFast_o, amplitudeSumNew_o,
             data_v, busy
   );
   modport slave (
      input  start, noteAmplitudes_i,
      output noteAmplitudes_o, noteAmplitudesFast_o, amplitudeSumNew_o,
             data_v, busy
   );
`endif
endinterface

// File: rtl/amp_preprocessor_seq.sv
// -----------------------------------------------------------------------------
// amp_preprocessor_seq
//   Time-multiplexed note-amplitude preprocessor. Captures one frame of
//   BIN_QTY unsigned W.D amplitudes, subtracts a saturating noise floor and
//   runs each bin through a slow and a fast single-pole IIR filter, one bin
//   per clock, while accumulating the sum of the floored amplitudes.
//
//   Ports
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   amp_preprocessor_seq_if.slave (start, frame in, filtered frames out,
//           amplitude sum, data_v pulse, busy, optional peak outputs)
//
//   Optional feature macro: AMPPRE_PEAK_EN
//     Tracks index/value of the largest floored amplitude of the frame
//     (lowest index wins ties) and publishes it together with the sum.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module amp_preprocessor_seq #(
   parameter int          W          = 6,
   parameter int          D          = 10,
   parameter int          BIN_QTY    = 12,
   parameter int unsigned LED_FLOOR  = 32'h0066,
   parameter int          SLOW_SHIFT = 3,
   parameter int          FAST_SHIFT = 1
) (
   input logic                  clk,
   input logic                  rst,
   amp_preprocessor_seq_if.slave bus
);
   localparam int            AW      = W + D;
   localparam int            IW      = $clog2(BIN_QTY);
   localparam int            SW      = AW + IW;
   localparam logic [AW-1:0] FLOOR_C = AW'(LED_FLOOR);
   localparam logic [IW-1:0] LAST_C  = IW'(BIN_QTY - 1);

   typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

   // Floor subtraction clamped at zero.
   function automatic logic [AW-1:0] floor_sub(input logic [AW-1:0] a);
      return (a > FLOOR_C) ? (a - FLOOR_C) : '0;
   endfunction

   // Clamp a signed intermediate into the unsigned W.D range.
   function automatic logic [AW-1:0] sat_u(input logic signed [AW+1:0] v);
      if (v[AW+1]) return '0;
      if (v[AW])   return '1;
      return v[AW-1:0];
   endfunction

   // y + ((x - y) >>> shift); the arithmetic shift floors toward -inf so a
   // decay toward zero always lands exactly on zero.
   function automatic logic [AW-1:0] iir_step(input logic [AW-1:0] y,
                                               input logic [AW-1:0] x,
                                               input int            shift);
      logic signed [AW:0]   diff;
      logic signed [AW:0]   step;
      logic signed [AW+1:0] sum;
      diff = $signed({1'b0, x}) - $signed({1'b0, y});
      step = diff >>> shift;
      sum  = $signed({2'b00, y}) + step;
      return sat_u(sum);
   endfunction

   state_t                     state_q;
   logic [BIN_QTY-1:0][AW-1:0] snap_q;
   logic [BIN_QTY-1:0][AW-1:0] slow_q;
   logic [BIN_QTY-1:0][AW-1:0] fast_q;
   logic [IW-1:0]              idx_q;
   logic [SW-1:0]              acc_q;
   logic [SW-1:0]              sum_q;
   logic                       data_v_q;
   logic                       busy_q;

   logic [AW-1:0]              x_d;
   logic [AW-1:0]              slow_d;
   logic [AW-1:0]              fast_d;
   logic [SW-1:0]              acc_d;

`ifdef AMPPRE_PEAK_EN
   logic [IW-1:0]              run_idx_q, run_idx_d, peak_idx_q;
   logic [AW-1:0]              run_amp_q, run_amp_d, peak_amp_q;
`endif

   // Shared single-bin datapath, addressed by idx_q.
   always_comb begin
      x_d    = floor_sub(snap_q[idx_q]);
      slow_d = iir_step(slow_q[idx_q], x_d, SLOW_SHIFT);
      fast_d = iir_step(fast_q[idx_q], x_d, FAST_SHIFT);
      acc_d  = acc_q + SW'(x_d);
`ifdef AMPPRE_PEAK_EN
      run_idx_d = run_idx_q;
      run_amp_d = run_amp_q;
      // Strict compare keeps the earliest bin on ties; an all-floored
      // frame never beats the zero start value, leaving index 0.
      if (x_d > run_amp_q) begin
         run_idx_d = idx_q;
         run_amp_d = x_d;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         snap_q   <= '0;
         slow_q   <= '0;
         fast_q   <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         sum_q    <= '0;
         data_v_q <= 1'b0;
         busy_q   <= 1'b0;
`ifdef AMPPRE_PEAK_EN
         run_idx_q  <= '0;
         run_amp_q  <= '0;
         peak_idx_q <= '0;
         peak_amp_q <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               data_v_q <= 1'b0;
               if (bus.start) begin
                  snap_q  <= bus.noteAmplitudes_i;
                  idx_q   <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= PROC;
`ifdef AMPPRE_PEAK_EN
                  run_idx_q <= '0;
                  run_amp_q <= '0;
`endif
               end
            end
            PROC: begin
               slow_q[idx_q] <= slow_d;
               fast_q[idx_q] <= fast_d;
               acc_q         <= acc_d;
`ifdef AMPPRE_PEAK_EN
               run_idx_q <= run_idx_d;
               run_amp_q <= run_amp_d;
`endif
               if (idx_q == LAST_C) begin
                  sum_q    <= acc_d;
                  data_v_q <= 1'b1;
                  state_q  <= DONE;
`ifdef AMPPRE_PEAK_EN
                  peak_idx_q <= run_idx_d;
                  peak_amp_q <= run_amp_d;
`endif
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               data_v_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.noteAmplitudes_o     = slow_q;
   assign bus.noteAmplitudesFast_o = fast_q;
   assign bus.amplitudeSumNew_o    = sum_q;
   assign bus.data_v               = data_v_q;
   assign bus.busy                 = busy_q;
`ifdef AMPPRE_PEAK_EN
   assign bus.peakIdx_o            = peak_idx_q;
   assign bus.peakAmp_o            = peak_amp_q;
`endif

endmodule
